spi_slave_to_apb: RTL and testbench
===================================

SPI_SLAVE_TO_APB -- requirements
Module: spi_slave_to_apb

Interface
REQ-001 Parameter APB_AW, default 32: PADDR width.
REQ-002 Parameter PCLK_PER_SCLK_MIN, default 8: minimum PCLK/SCLK ratio the block SHALL support.
REQ-003 Port PCLK, input, 1: single clock for the whole block.
REQ-004 Port PRESET, input, 1: asynchronous, active-high reset.
REQ-005 Port spi_sclk, input, 1: SPI clock from the external master, asynchronous to PCLK.
REQ-006 Port spi_ss_n, input, 1: active-low slave select.
REQ-007 Port spi_mosi, input, 1: serial data in.
REQ-008 Port spi_miso, output, 1: serial data out.
REQ-009 Port PADDR, output, APB_AW: APB address.
REQ-010 Ports PSEL, PENABLE and PWRITE: outputs, 1 bit each, APB master controls.
REQ-011 Port PWDATA, output, 32: APB write data.
REQ-012 Port PRDATA, input, 32: APB read data.
REQ-013 Port PREADY, input, 1: APB ready.
REQ-014 Port PSLVERR, input, 1: APB slave error.
REQ-015 Port frame_err, output, 1: one-PCLK pulse when a frame is discarded.

Function
REQ-016 The block SHALL pass spi_sclk, spi_ss_n and spi_mosi through 2-flop synchronizers, then detect edges on the synchronized values.
REQ-017 SPI mode 0, MSB first, 16-bit frames: mosi SHALL be sampled on each synced SCLK rise; miso SHALL change on each synced SCLK fall.
REQ-018 The bit counter SHALL clear on the synced ss_n fall, increment per SCLK rise, and saturate at 16.
REQ-019 Frame format: bit15 = write flag; bits14:8 = addr7; bits7:0 = wdata.
REQ-020 On the synced ss_n rise with count == 16, the block SHALL issue frame_valid; with count != 16 it SHALL discard the frame and pulse frame_err.
REQ-021 A frame_valid while the FSM is not IDLE SHALL be discarded, SHALL pulse frame_err, and SHALL set the sticky overrun bit.
REQ-022 APB FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-023 FSM transitions: IDLE->SETUP on an accepted frame_valid; SETUP->ACCESS unconditionally; ACCESS->IDLE when PREADY = 1; otherwise the FSM stays in ACCESS.
REQ-024 In SETUP: PSEL = 1, PENABLE = 0. In ACCESS: PSEL = 1, PENABLE = 1. PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through completion.
REQ-025 PADDR SHALL equal the zero-extended {addr7, 2'b00}; PWDATA SHALL equal the zero-extended wdata.
REQ-026 PSEL SHALL assert in the PCLK cycle after frame_valid.
REQ-027 On completion: a read SHALL latch PRDATA[7:0] into rd_buf; every transfer SHALL latch PSLVERR into last_err.
REQ-028 On the synced ss_n fall, tx_shift SHALL load {last_err, overrun, busy, 5'b0, rd_buf}, and miso SHALL drive bit15 immediately.
REQ-029 Reads therefore return data in the following frame.
REQ-030 overrun SHALL clear after it has been loaded into tx_shift.
REQ-031 spi_miso SHALL be 0 while ss_n is high.
REQ-032 If ss_n deasserts mid-APB transfer, the transfer SHALL still complete normally.
REQ-033 A frame that arrives in the same cycle as the ACCESS->IDLE transition SHALL be discarded, since the FSM is not IDLE.

Reset
REQ-034 PRESET SHALL asynchronously return the FSM to IDLE.
REQ-035 PRESET SHALL force PSEL, PENABLE, PWRITE, PADDR, PWDATA, spi_miso and frame_err to 0.
REQ-036 PRESET SHALL clear rd_buf, last_err, overrun, the counters and the synchronizers to 0, with ss_n sync at 1.
REQ-037 A reset during ACCESS SHALL abort the transfer with no completion side effects.

Configuration
REQ-038 Macro SPI_SLV_APB_TIMEOUT_EN defined: a 5-bit counter SHALL run in ACCESS; after 16 cycles without PREADY the FSM SHALL return to IDLE, set last_err = 1 and leave rd_buf unchanged.
REQ-039 Macro SPI_SLV_APB_TIMEOUT_EN undefined: ACCESS SHALL wait indefinitely for PREADY, and no timeout logic SHALL exist.

Structure
REQ-040 Package spi_apb_pkg SHALL hold the state_t enum (IDLE, SETUP, ACCESS), FRAME_W = 16, the field bit positions and the status-byte bit positions.
REQ-041 Sub-module spi_sync2 SHALL be a parameterized-width 2-flop synchronizer, instantiated once for {sclk, ss_n, mosi}.

Verification
REQ-042 Write frame 16'h8A5C, PREADY tied high -> one APB write with PADDR = 32'h28, PWDATA = 32'h5C, PSEL high for 2 cycles.
REQ-043 Read frame 16'h0300, slave returns PRDATA = 32'h0000_00C3, then a second frame -> the MISO word of the second frame equals 16'h00C3.
REQ-044 12-bit frame (ss_n raised early) -> frame_err pulses once and no PSEL.
REQ-045 Second frame completes while PREADY is held low -> frame_err pulses and the next MISO status bit6 (overrun) = 1; the status of the following frame shows overrun = 0.
REQ-046 PRESET asserted mid-ACCESS -> PSEL and PENABLE drop asynchronously, the FSM is IDLE, and the next MISO word is 16'h0000.
REQ-047 With SPI_SLV_APB_TIMEOUT_EN and PREADY stuck low -> IDLE after 16 ACCESS cycles, and the next MISO bit15 = 1.

Source files
------------

// File: rtl/spi_apb_pkg.sv
// rtl/spi_apb_pkg.sv - shared types, frame field positions and status-byte layout for the SPI-to-APB bridge
package spi_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam int FRAME_W  = 16;
   localparam int CNT_W    = 5;
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);

   localparam int WR_BIT   = 15;
   localparam int ADDR_MSB = 14;
   localparam int ADDR_LSB = 8;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;

   localparam int STAT_ERR_BIT  = 7;
   localparam int STAT_OVR_BIT  = 6;
   localparam int STAT_BUSY_BIT = 5;

   // Upper byte carries status flags, lower byte the last read data.
   function automatic logic [FRAME_W-1:0] status_word(input logic err, input logic ovr,
                                                      input logic busy, input logic [7:0] rd);
      logic [7:0] st;
      st = '0;
      st[STAT_ERR_BIT]  = err;
      st[STAT_OVR_BIT]  = ovr;
      st[STAT_BUSY_BIT] = busy;
      return {st, rd};
   endfunction

endpackage

// File: rtl/spi_sync2.sv
// rtl/spi_sync2.sv - parameterized-width two-flop synchronizer with per-bit reset value
module spi_sync2 #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/spi_slave_to_apb.sv
// rtl/spi_slave_to_apb.sv - SPI mode-0 slave turning 16-bit frames into APB transfers
// Optional ACCESS timeout is compiled in with SPI_SLV_APB_TIMEOUT_EN.
module spi_slave_to_apb
   import spi_apb_pkg::*;
#(
   parameter int APB_AW            = 32,
   parameter int PCLK_PER_SCLK_MIN = 8
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              spi_sclk,
   input  logic              spi_ss_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [APB_AW-1:0] PADDR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [31:0]       PWDATA,
   input  logic [31:0]       PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR,
   output logic              frame_err
);

   // Each synced SCLK phase must outlast the 3-cycle sync+edge latency.
   localparam int unused_sclk_ratio = PCLK_PER_SCLK_MIN;
   logic unused_prdata_hi;
   assign unused_prdata_hi = ^PRDATA[31:8];

   logic [2:0] sync_out;
   logic       sclk_s, ss_n_s, mosi_s;

   spi_sync2 #(.W(3), .RST_VAL(3'b010)) u_sync (
      .clk (PCLK),
      .rst (PRESET),
      .d   ({spi_sclk, spi_ss_n, spi_mosi}),
      .q   (sync_out)
   );
   assign {sclk_s, ss_n_s, mosi_s} = sync_out;

   state_t             state_q, state_d;
   logic               sclk_prev_q, sclk_prev_d, ss_n_prev_q, ss_n_prev_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
   logic [7:0]         rd_buf_q, rd_buf_d, wdata_q, wdata_d;
   logic [6:0]         addr7_q, addr7_d;
   logic               pwrite_q, pwrite_d, last_err_q, last_err_d;
   logic               overrun_q, overrun_d, frame_err_q, frame_err_d;
`ifdef SPI_SLV_APB_TIMEOUT_EN
   logic [4:0]         tmo_cnt_q, tmo_cnt_d;
`endif

   logic sclk_rise, sclk_fall, ss_fall, ss_rise, frame_valid;

   assign sclk_rise   = sclk_s & ~sclk_prev_q;
   assign sclk_fall   = ~sclk_s & sclk_prev_q;
   assign ss_fall     = ~ss_n_s & ss_n_prev_q;
   assign ss_rise     = ss_n_s & ~ss_n_prev_q;
   assign frame_valid = ss_rise & (bit_cnt_q == FRAME_CNT);

   always_comb begin
      sclk_prev_d = sclk_s;
      ss_n_prev_d = ss_n_s;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      if (ss_fall) begin
         bit_cnt_d  = '0;
         tx_shift_d = status_word(last_err_q, overrun_q, state_q != IDLE, rd_buf_q);
      end else if (!ss_n_s) begin
         if (sclk_rise && bit_cnt_q < FRAME_CNT) begin
            rx_shift_d = {rx_shift_q[FRAME_W-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 1'b1;
         end
         if (sclk_fall) begin
            tx_shift_d = {tx_shift_q[FRAME_W-2:0], 1'b0};
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      PSEL        = 1'b0;
      PENABLE     = 1'b0;
      addr7_d     = addr7_q;
      wdata_d     = wdata_q;
      pwrite_d    = pwrite_q;
      rd_buf_d    = rd_buf_q;
      last_err_d  = last_err_q;
      overrun_d   = ss_fall ? 1'b0 : overrun_q;
      frame_err_d = (ss_rise & ~frame_valid) | (frame_valid & (state_q != IDLE));
`ifdef SPI_SLV_APB_TIMEOUT_EN
      tmo_cnt_d   = (state_q == ACCESS) ? tmo_cnt_q + 5'd1 : 5'd0;
`endif
      if (frame_valid && state_q != IDLE) begin
         overrun_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (frame_valid) begin
               state_d  = SETUP;
               pwrite_d = rx_shift_q[WR_BIT];
               addr7_d  = rx_shift_q[ADDR_MSB:ADDR_LSB];
               wdata_d  = rx_shift_q[DATA_MSB:DATA_LSB];
            end
         end
         SETUP: begin
            PSEL    = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            if (PREADY) begin
               state_d    = IDLE;
               last_err_d = PSLVERR;
               if (!pwrite_q) begin
                  rd_buf_d = PRDATA[7:0];
               end
`ifdef SPI_SLV_APB_TIMEOUT_EN
            end else if (tmo_cnt_q == 5'd15) begin
               state_d    = IDLE;
               last_err_d = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q     <= IDLE;
         sclk_prev_q <= 1'b0;
         ss_n_prev_q <= 1'b1;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         rd_buf_q    <= '0;
         wdata_q     <= '0;
         addr7_q     <= '0;
         pwrite_q    <= 1'b0;
         last_err_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef SPI_SLV_APB_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         sclk_prev_q <= sclk_prev_d;
         ss_n_prev_q <= ss_n_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         rd_buf_q    <= rd_buf_d;
         wdata_q     <= wdata_d;
         addr7_q     <= addr7_d;
         pwrite_q    <= pwrite_d;
         last_err_q  <= last_err_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
`ifdef SPI_SLV_APB_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   assign spi_miso  = tx_shift_q[FRAME_W-1] & ~ss_n_s;
   assign PADDR     = APB_AW'({addr7_q, 2'b00});
   assign PWDATA    = {24'b0, wdata_q};
   assign PWRITE    = pwrite_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_to_apb.sv
// tb/tb_spi_slave_to_apb.sv - directed vector bench for spi_slave_to_apb
module tb_spi_slave_to_apb;

   localparam int H = 8;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic        spi_sclk = 1'b0;
   logic        spi_ss_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic [31:0] PADDR;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA = '0;
   logic        PREADY = 1'b1;
   logic        PSLVERR = 1'b0;
   logic        frame_err;

   spi_slave_to_apb #(.APB_AW(32), .PCLK_PER_SCLK_MIN(8)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .PADDR(PADDR), .PSEL(PSEL),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .frame_err(frame_err)
   );

   always #5 PCLK = ~PCLK;

   int          psel_total = 0;
   int          ferr_total = 0;
   int          stab_err = 0;
   logic [31:0] cap_paddr = '0, cap_pwdata = '0;
   logic        cap_pwrite = 1'b0;

   always @(negedge PCLK) begin
      if (PSEL) psel_total++;
      if (frame_err) ferr_total++;
      if (PSEL && !PENABLE) begin
         cap_paddr  = PADDR;
         cap_pwdata = PWDATA;
         cap_pwrite = PWRITE;
      end else if (PSEL && PENABLE &&
                   (PADDR !== cap_paddr || PWDATA !== cap_pwdata || PWRITE !== cap_pwrite)) begin
         stab_err++;
      end
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [15:0] rx);
      rx = '0;
      spi_ss_n = 1'b0;
      repeat (H) @(negedge PCLK);
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = w[15-i];
         repeat (H) @(negedge PCLK);
         rx[15-i] = spi_miso;
         spi_sclk = 1'b1;
         repeat (H) @(negedge PCLK);
         spi_sclk = 1'b0;
      end
      repeat (H) @(negedge PCLK);
      spi_ss_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (2*H) @(negedge PCLK);
   endtask

   typedef struct {
      logic [15:0] frame;
      logic [31:0] prdata;
      logic        pslverr;
      logic        exp_wr;
      logic [31:0] exp_paddr;
      logic [31:0] exp_pwdata;
      logic [15:0] exp_miso;
   } vec_t;

   vec_t        vecs[6];
   logic [15:0] miso_w;
   int          base_psel, base_ferr;

   initial begin
      vecs[0] = '{16'h8A5C, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0028, 32'h0000_005C, 16'h0000};
      vecs[1] = '{16'h0300, 32'h0000_00C3, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_0000, 16'h0000};
      vecs[2] = '{16'hFFAA, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_01FC, 32'h0000_00AA, 16'h00C3};
      vecs[3] = '{16'h7F11, 32'hFFFF_FF5A, 1'b0, 1'b0, 32'h0000_01FC, 32'h0000_0011, 16'h80C3};
      vecs[4] = '{16'h0000, 32'h0000_0012, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 16'h005A};
      vecs[5] = '{16'h8001, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0001, 16'h0012};

      repeat (3) @(negedge PCLK);
      check("rst_psel", 32'(PSEL), 32'h0);
      check("rst_penable", 32'(PENABLE), 32'h0);
      check("rst_paddr", PADDR, 32'h0);
      check("rst_pwdata", PWDATA, 32'h0);
      check("rst_miso", 32'(spi_miso), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      PRESET = 1'b0;
      repeat (4) @(negedge PCLK);

      for (int i = 0; i < 6; i++) begin
         PRDATA    = vecs[i].prdata;
         PSLVERR   = vecs[i].pslverr;
         PREADY    = 1'b1;
         base_psel = psel_total;
         spi_frame(vecs[i].frame, 16, miso_w);
         check($sformatf("v%0d_miso", i), 32'(miso_w), 32'(vecs[i].exp_miso));
         check($sformatf("v%0d_paddr", i), cap_paddr, vecs[i].exp_paddr);
         check($sformatf("v%0d_pwdata", i), cap_pwdata, vecs[i].exp_pwdata);
         check($sformatf("v%0d_pwrite", i), 32'(cap_pwrite), 32'(vecs[i].exp_wr));
         check($sformatf("v%0d_psel_cycles", i), 32'(psel_total - base_psel), 32'd2);
      end
      PSLVERR = 1'b0;

      // Short frame: discarded, one error pulse, no APB activity
      base_psel = psel_total;
      base_ferr = ferr_total;
      spi_frame(16'h8123, 12, miso_w);
      check("short_frame_err", 32'(ferr_total - base_ferr), 32'd1);
      check("short_no_psel", 32'(psel_total - base_psel), 32'd0);

      // Overrun: second frame arrives while ACCESS is stalled
      PREADY = 1'b0;
      PRDATA = 32'h0000_0077;
      spi_frame(16'h0100, 16, miso_w);
      check("stall_psel", 32'(PSEL), 32'h1);
      check("stall_penable", 32'(PENABLE), 32'h1);
      base_ferr = ferr_total;
      spi_frame(16'h0200, 16, miso_w);
      check("busy_miso", 32'(miso_w), 32'h0000_2012);
      check("ovr_frame_err", 32'(ferr_total - base_ferr), 32'd1);
      PREADY = 1'b1;
      repeat (5) @(negedge PCLK);
      spi_frame(16'h8000, 16, miso_w);
      check("ovr_miso", 32'(miso_w), 32'h0000_4077);
      spi_frame(16'h0000, 16, miso_w);
      check("ovr_cleared_miso", 32'(miso_w), 32'h0000_0077);

      // Reset during ACCESS
      PREADY = 1'b0;
      spi_frame(16'h0500, 16, miso_w);
      check("pre_rst_psel", 32'(PSEL), 32'h1);
      @(negedge PCLK);
      #1 PRESET = 1'b1;
      #1;
      check("async_rst_psel", 32'(PSEL), 32'h0);
      check("async_rst_penable", 32'(PENABLE), 32'h0);
      @(negedge PCLK);
      PRESET = 1'b0;
      PREADY = 1'b1;
      PRDATA = 32'h0000_0099;
      repeat (4) @(negedge PCLK);
      check("post_rst_idle", 32'(PSEL), 32'h0);
      spi_frame(16'h0000, 16, miso_w);
      check("post_rst_miso", 32'(miso_w), 32'h0000_0000);

`ifdef SPI_SLV_APB_TIMEOUT_EN
      PREADY    = 1'b0;
      base_psel = psel_total;
      spi_frame(16'h0100, 16, miso_w);
      repeat (30) @(negedge PCLK);
      check("tmo_psel_cycles", 32'(psel_total - base_psel), 32'd17);
      PREADY = 1'b1;
      spi_frame(16'h0000, 16, miso_w);
      check("tmo_miso", 32'(miso_w), 32'h0000_8099);
`endif

      check("apb_stability", 32'(stab_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
